// File: rtl/vx_gbar_hub.sv
// Global barrier hub: round-robin arbitration over socket channels feeding a
// multi-ID barrier table with per-core arrival masks, duplicate detection and release pulses.
module vx_gbar_hub #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_BARRIERS = 16,
  parameter int NUM_CORES    = 8,
  localparam int BAR_W  = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int REQ_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        req_valid,
  input  logic [NUM_REQS*BAR_W-1:0]  req_id,
  input  logic [NUM_REQS*CORE_W-1:0] req_size_m1,
  input  logic [NUM_REQS*CORE_W-1:0] req_core_id,
  output logic [NUM_REQS-1:0]        req_ready,
  output logic                       rsp_valid,
  output logic [BAR_W-1:0]           rsp_id,
  output logic                       err_dup,
  output logic                       busy
);

  logic [REQ_W-1:0]    ptr_reg, ptr_next;
  logic [NUM_REQS-1:0] grant;
  logic [REQ_W-1:0]    grant_idx;
  logic                grant_any;

  logic [BAR_W-1:0]    acc_id;
  logic [CORE_W-1:0]   acc_size;
  logic [CORE_W-1:0]   acc_core;

  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q;
  logic [NUM_BARRIERS-1:0][CORE_W-1:0]    cnt_q;

  logic [NUM_CORES-1:0] cur_mask;
  logic [CORE_W-1:0]    cur_cnt;
  logic [NUM_CORES-1:0] core_onehot;
  logic                 is_dup, is_rel, is_arr;

  logic                 rsp_valid_reg;
  logic [BAR_W-1:0]     rsp_id_reg;
  logic                 err_dup_reg;

  // Round-robin: first valid lane at or after the pointer wins; reset masks all grants.
  always_comb begin
    int lane;
    lane      = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (!reset) begin
      for (int k = 0; k < NUM_REQS; k++) begin
        lane = (int'(ptr_reg) + k) % NUM_REQS;
        if (!grant_any && req_valid[lane]) begin
          grant_any   = 1'b1;
          grant[lane] = 1'b1;
          grant_idx   = REQ_W'(lane);
        end
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      ptr_next = (grant_idx == REQ_W'(NUM_REQS - 1)) ? '0 : grant_idx + REQ_W'(1);
    end
  end

  assign req_ready = grant;

  // Grant is one-hot, so an OR-mux selects the winning lane's fields.
  always_comb begin
    acc_id   = '0;
    acc_size = '0;
    acc_core = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        acc_id   = acc_id   | req_id[i*BAR_W +: BAR_W];
        acc_size = acc_size | req_size_m1[i*CORE_W +: CORE_W];
        acc_core = acc_core | req_core_id[i*CORE_W +: CORE_W];
      end
    end
  end

  always_comb begin
    cur_mask = '0;
    cur_cnt  = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (acc_id == BAR_W'(b)) begin
        cur_mask = mask_q[b];
        cur_cnt  = cnt_q[b];
      end
    end
  end

  always_comb begin
    core_onehot = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      core_onehot[c] = (acc_core == CORE_W'(c));
    end
  end

  // Duplicate takes precedence; a release needs a fresh core and a matching count.
  assign is_dup = grant_any && ((cur_mask & core_onehot) != '0);
  assign is_rel = grant_any && !is_dup &&
                  ((cur_mask == '0) ? (acc_size == '0)
                                    : (cur_cnt == acc_size - CORE_W'(1)));
  assign is_arr = grant_any && !is_dup && !is_rel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BARRIERS; gi++) begin : g_bar
      logic                 hit;
      logic [NUM_CORES-1:0] mask_reg;
      logic [CORE_W-1:0]    cnt_reg;

      assign hit = (acc_id == BAR_W'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mask_reg <= '0;
          cnt_reg  <= '0;
        end else if (hit && is_rel) begin
          mask_reg <= '0;
          cnt_reg  <= '0;
        end else if (hit && is_arr) begin
          mask_reg <= mask_reg | core_onehot;
          cnt_reg  <= (mask_reg == '0) ? '0 : cnt_reg + CORE_W'(1);
        end
      end

      assign mask_q[gi] = mask_reg;
      assign cnt_q[gi]  = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      err_dup_reg   <= 1'b0;
    end else begin
      ptr_reg       <= ptr_next;
      rsp_valid_reg <= is_rel;
      err_dup_reg   <= is_dup;
      if (is_rel) begin
        rsp_id_reg <= acc_id;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign err_dup   = err_dup_reg;
  // Derived from the mask registers only, so reset clears it immediately.
  assign busy      = |mask_q;

endmodule

// File: tb/tb_vx_gbar_hub.sv
// Self-checking bench for vx_gbar_hub: directed vector table, reset corner case,
// and randomized traffic against a set-based barrier model.
module tb_vx_gbar_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_id;
  logic [11:0] req_size_m1;
  logic [11:0] req_core_id;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_id;
  logic        err_dup;
  logic        busy;

  vx_gbar_hub #(.NUM_REQS(4), .NUM_BARRIERS(16), .NUM_CORES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_id(req_id),
    .req_size_m1(req_size_m1), .req_core_id(req_core_id),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .err_dup(err_dup), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cyc  = 0;

  // Model: which cores have arrived at each barrier, plus the round-robin start lane.
  bit seen [16][8];
  int ptr;
  logic [3:0] last_ready;

  typedef struct packed {
    logic [3:0]  valid;
    logic [15:0] ids;
    logic [11:0] sizes;
    logic [11:0] cores;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [3:0]  exp_rid;
    logic        exp_dup;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int arrivals(input int b);
    int n = 0;
    for (int c = 0; c < 8; c++) n += seen[b][c] ? 1 : 0;
    return n;
  endfunction

  function automatic void model_clear();
    for (int b = 0; b < 16; b++)
      for (int c = 0; c < 8; c++) seen[b][c] = 1'b0;
    ptr = 0;
  endfunction

  task automatic do_cycle(input logic [3:0] v, input logic [15:0] ids,
                          input logic [11:0] sz, input logic [11:0] cr);
    int g, b, c, s;
    logic exp_rv, exp_dup, exp_busy;
    logic [3:0] exp_rid;
    req_valid = v; req_id = ids; req_size_m1 = sz; req_core_id = cr;
    #1;
    g = model_grant(v);
    last_ready = req_ready;
    check("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    exp_rv = 1'b0; exp_dup = 1'b0; exp_rid = '0;
    if (g >= 0) begin
      b = int'(ids[g*4 +: 4]); s = int'(sz[g*3 +: 3]); c = int'(cr[g*3 +: 3]);
      ptr = (g + 1) % 4;
      if (seen[b][c]) exp_dup = 1'b1;
      else if (arrivals(b) == s) begin
        for (int k = 0; k < 8; k++) seen[b][k] = 1'b0;
        exp_rv = 1'b1; exp_rid = 4'(b);
      end else seen[b][c] = 1'b1;
    end
    exp_busy = 1'b0;
    for (int bb = 0; bb < 16; bb++) if (arrivals(bb) != 0) exp_busy = 1'b1;
    @(posedge clk); #1;
    n_cyc++;
    check("rsp_valid", rsp_valid, exp_rv);
    check("err_dup", err_dup, exp_dup);
    check("busy", busy, exp_busy);
    if (exp_rv) check("rsp_id", rsp_id, exp_rid);
    $display("cyc %0d v=%b ready=%b rsp_valid=%b rsp_id=%0d err_dup=%b busy=%b",
             n_cyc, v, last_ready, rsp_valid, rsp_id, err_dup, busy);
  endtask

  initial begin
    // valid, ids, sizes, cores, exp_ready, exp_rv, exp_rid, exp_dup, exp_busy
    vecs[0]  = '{4'b0001, 16'h0003, 12'h000, 12'h000, 4'b0001, 1'b1, 4'd3, 1'b0, 1'b0};
    vecs[1]  = '{4'b1000, 16'h2000, 12'h000, 12'h000, 4'b1000, 1'b1, 4'd2, 1'b0, 1'b0};
    vecs[2]  = '{4'b1111, 16'h5555, 12'h6DB, 12'h688, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[3]  = '{4'b1110, 16'h5555, 12'h6DB, 12'h688, 4'b0010, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[4]  = '{4'b1100, 16'h5555, 12'h6DB, 12'h688, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[5]  = '{4'b1000, 16'h5555, 12'h6DB, 12'h688, 4'b1000, 1'b1, 4'd5, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 16'h0001, 12'h001, 12'h002, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[7]  = '{4'b0010, 16'h0010, 12'h008, 12'h010, 4'b0010, 1'b0, 4'd0, 1'b1, 1'b1};
    vecs[8]  = '{4'b0100, 16'h0100, 12'h040, 12'h100, 4'b0100, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[9]  = '{4'b1000, 16'h0000, 12'h200, 12'h000, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[10] = '{4'b0001, 16'h0007, 12'h001, 12'h002, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[11] = '{4'b0010, 16'h0000, 12'h008, 12'h008, 4'b0010, 1'b1, 4'd0, 1'b0, 1'b1};
    vecs[12] = '{4'b0100, 16'h0700, 12'h040, 12'h0C0, 4'b0100, 1'b1, 4'd7, 1'b0, 1'b0};
    vecs[13] = '{4'b0101, 16'h0604, 12'h000, 12'h000, 4'b0001, 1'b1, 4'd4, 1'b0, 1'b0};
    vecs[14] = '{4'b0101, 16'h0604, 12'h000, 12'h000, 4'b0100, 1'b1, 4'd6, 1'b0, 1'b0};
    vecs[15] = '{4'b0101, 16'h0604, 12'h000, 12'h000, 4'b0001, 1'b1, 4'd4, 1'b0, 1'b0};
    vecs[16] = '{4'b0101, 16'h0604, 12'h000, 12'h000, 4'b0100, 1'b1, 4'd6, 1'b0, 1'b0};

    model_clear();
    reset = 1'b1;
    req_valid = 4'b1111; req_id = '0; req_size_m1 = '0; req_core_id = '0;
    @(posedge clk); @(posedge clk); #2;
    check("reset req_ready", req_ready, 4'b0000);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_id", rsp_id, 4'd0);
    check("reset err_dup", err_dup, 1'b0);
    check("reset busy", busy, 1'b0);
    #3 reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      do_cycle(vecs[i].valid, vecs[i].ids, vecs[i].sizes, vecs[i].cores);
      check($sformatf("vec%0d ready", i), last_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d rsp_valid", i), rsp_valid, vecs[i].exp_rv);
      check($sformatf("vec%0d err_dup", i), err_dup, vecs[i].exp_dup);
      check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      if (vecs[i].exp_rv) check($sformatf("vec%0d rsp_id", i), rsp_id, vecs[i].exp_rid);
    end

    // Two of three arrivals on id 9, then an asynchronous reset mid-cycle.
    do_cycle(4'b1111, 16'h9999, 12'h492, 12'h688);
    do_cycle(4'b1111, 16'h9999, 12'h492, 12'h688);
    check("pre-reset busy", busy, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("async reset req_ready", req_ready, 4'b0000);
    check("async reset rsp_valid", rsp_valid, 1'b0);
    check("async reset rsp_id", rsp_id, 4'd0);
    check("async reset err_dup", err_dup, 1'b0);
    check("async reset busy", busy, 1'b0);
    model_clear();
    @(posedge clk); #4;
    check("held reset req_ready", req_ready, 4'b0000);
    check("held reset busy", busy, 1'b0);
    reset = 1'b0;
    do_cycle(4'b1111, 16'h9999, 12'h492, 12'h688);
    check("fresh arrival 1 ready", last_ready, 4'b0001);
    check("fresh arrival 1 rsp_valid", rsp_valid, 1'b0);
    do_cycle(4'b1111, 16'h9999, 12'h492, 12'h688);
    check("fresh arrival 2 rsp_valid", rsp_valid, 1'b0);
    do_cycle(4'b1111, 16'h9999, 12'h492, 12'h688);
    check("fresh arrival 3 rsp_valid", rsp_valid, 1'b1);
    check("fresh arrival 3 rsp_id", rsp_id, 4'd9);

    // Randomized traffic on a few IDs so barriers collide, duplicate and release.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ids;
      logic [11:0] sz, cr;
      for (int l = 0; l < 4; l++) begin
        ids[l*4 +: 4] = 4'($urandom_range(0, 3));
        sz[l*3 +: 3]  = 3'($urandom_range(0, 3));
        cr[l*3 +: 3]  = 3'($urandom_range(0, 7));
      end
      do_cycle(4'($urandom_range(0, 15)), ids, sz, cr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
